dds_sweep_ctrl: RTL and testbench
=================================

Name: dds_sweep_ctrl

Overview:
- Linear frequency/phase sweep controller sitting directly upstream of the DDS core.
- Drives the DDS frequency control word (f_ctrl, 20 bit) and phase control word (p_ctrl, 12 bit).
- Steps f_ctrl from a start word to a stop word in fixed increments, holding each value for a programmable dwell time.
- Supports single-shot and continuous (repeating) sweeps, with a start/busy/done handshake toward the system controller.

Parameters:
F_W, 20, frequency control word width (matches DDS f_ctrl)
P_W, 12, phase control word width (matches DDS p_ctrl)
DWELL_W, 16, dwell counter width

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
start  input  1  single-cycle sweep request; accepted only when busy=0
stop_req  input  1  abort request; honoured only when busy=1
cont  input  1  continuous mode; sampled with start
f_start  input  F_W  first frequency word
f_stop  input  F_W  last frequency word
f_step  input  F_W  frequency increment magnitude
dwell  input  DWELL_W  clocks per step; 0 treated as 1
p_init  input  P_W  phase word at sweep (re)start
p_step  input  P_W  phase increment per frequency step
f_ctrl  output  F_W  frequency word to DDS
p_ctrl  output  P_W  phase word to DDS
busy  output  1  sweep in progress
done  output  1  one-cycle pulse at sweep end or abort
step_stb  output  1  one-cycle pulse whenever f_ctrl/p_ctrl load a new value

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. All outputs are registered.
- Reset value: f_ctrl=0, p_ctrl=0, busy=0, done=0, step_stb=0, state=IDLE, dwell counter=0. Reset asserted mid-sweep clears everything immediately, with no done pulse.
- States:
  - IDLE: wait for start.
  - DWELL: hold the current word and count dwell clocks.
  - Exit to IDLE: taken at sweep end or on abort. Done is pulsed on this transition.
- IDLE, start=1 at edge N:
  - Shadow registers capture f_start, f_stop, f_step, dwell, p_init, p_step and cont. Input changes after edge N are ignored until the next start.
  - Direction: up if f_stop >= f_start, else down.
  - At edge N outputs become f_ctrl=f_start, p_ctrl=p_init, busy=1, step_stb=1 (one cycle). State goes to DWELL.
- DWELL: each f_ctrl value is held for exactly D = max(dwell,1) cycles. At the last dwell cycle:
  - f_ctrl != f_stop:
    - remaining = |f_stop - f_ctrl| (computed at F_W+1 bits, no overflow).
    - If f_step == 0 or f_step >= remaining: f_ctrl = f_stop (clamp; never overshoot).
    - Otherwise f_ctrl = f_ctrl + f_step (up) or f_ctrl - f_step (down).
    - p_ctrl = p_ctrl + p_step mod 2^P_W.
    - step_stb=1.
  - f_ctrl == f_stop, cont=0: go to IDLE, busy=0, done=1 for one cycle. f_ctrl and p_ctrl hold their last values.
  - f_ctrl == f_stop, cont=1: f_ctrl=f_start, p_ctrl=p_init, step_stb=1, remain in DWELL. No done pulse.
- f_start == f_stop: single point. Hold for D cycles, then done (or repeat if cont=1).
- stop_req while busy: at the next edge go to IDLE, busy=0, done=1, step_stb=0. f_ctrl and p_ctrl hold their current values. Takes priority over a step in the same cycle.
- stop_req while idle has no effect. start while busy is ignored.
- start and stop_req asserted together in IDLE: start is accepted.
- Latency: start to first f_ctrl value is 1 clock. Total single-shot duration from start edge to done edge = (number of distinct f_ctrl values) × D clocks.

Test Plan:
- Up sweep: f_start=1000, f_stop=1300, f_step=100, dwell=3, cont=0, p_init=0, p_step=5 -> f_ctrl 1000/1100/1200/1300, each for 3 cycles; p_ctrl 0/5/10/15; step_stb pulses ×4; done pulses 12 clocks after the start edge, coincident with busy falling.
- Clamp + down sweep: f_start=1250, f_stop=1000, f_step=100, dwell=1 -> f_ctrl 1250/1150/1050/1000, each for 1 cycle; done after 4 clocks.
- Continuous + phase wrap: f_start=10, f_stop=20, f_step=10, dwell=2, cont=1, p_init=4094, p_step=3 -> p_ctrl 4094/1/4094/1…, f_ctrl 10/20/10/20…; no done while running; busy stays 1.
- Abort: during the up-sweep scenario, assert stop_req while f_ctrl=1100 -> next edge busy=0, done=1; f_ctrl holds 1100; a following start restarts at 1000.
- Edge cases:
  - dwell=0 and f_step=0 with 1000->5000 -> f_ctrl 1000 then 5000, one cycle each.
  - f_start=f_stop=777 -> single 777 value, done after D cycles.
  - start pulsed while busy -> ignored.
- Async reset mid-sweep: assert rst between clock edges -> f_ctrl=0, p_ctrl=0, busy=0, done=0 immediately; no pulse after release.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: linear frequency/phase sweep controller feeding a DDS core.
// Steps f_ctrl from f_start to f_stop in f_step increments with a per-step
// dwell time, optionally repeating. p_ctrl advances by p_step on each new
// frequency word. All sweep settings are captured on the accepted start.
module dds_sweep_ctrl #(
   parameter int F_W     = 20,
   parameter int P_W     = 12,
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop_req,
   input  logic               cont,
   input  logic [F_W-1:0]     f_start,
   input  logic [F_W-1:0]     f_stop,
   input  logic [F_W-1:0]     f_step,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [P_W-1:0]     p_init,
   input  logic [P_W-1:0]     p_step,
   output logic [F_W-1:0]     f_ctrl,
   output logic [P_W-1:0]     p_ctrl,
   output logic               busy,
   output logic               done,
   output logic               step_stb
);

   localparam logic S_IDLE  = 1'b0;
   localparam logic S_DWELL = 1'b1;

   logic               state;
   logic [DWELL_W-1:0] dwell_cnt;

   // Shadow copies of the sweep settings, frozen at the accepted start
   logic [F_W-1:0]     start_s;
   logic [F_W-1:0]     stop_s;
   logic [F_W-1:0]     step_s;
   logic [DWELL_W-1:0] dwell_s;
   logic [P_W-1:0]     p_init_s;
   logic [P_W-1:0]     p_step_s;
   logic               cont_s;
   logic               dir_up;

   logic [F_W:0]       remaining;
   logic [F_W-1:0]     next_f;
   logic               last_dwell;

   // Next frequency word: step toward f_stop, clamping so it never overshoots
   always_comb begin
      remaining = '0;
      next_f    = stop_s;
      if (dir_up) begin
         remaining = {1'b0, stop_s} - {1'b0, f_ctrl};
      end else begin
         remaining = {1'b0, f_ctrl} - {1'b0, stop_s};
      end
      if (step_s == '0 || {1'b0, step_s} >= remaining) begin
         next_f = stop_s;
      end else if (dir_up) begin
         next_f = f_ctrl + step_s;
      end else begin
         next_f = f_ctrl - step_s;
      end
   end

   // Final cycle of the current dwell period (dwell_s is already at least 1)
   always_comb begin
      last_dwell = (dwell_cnt == dwell_s - DWELL_W'(1));
   end

   // Sweep sequencer: start capture, dwell counting, stepping, repeat and abort
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         dwell_cnt <= '0;
         f_ctrl    <= '0;
         p_ctrl    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         step_stb  <= 1'b0;
         start_s   <= '0;
         stop_s    <= '0;
         step_s    <= '0;
         dwell_s   <= '0;
         p_init_s  <= '0;
         p_step_s  <= '0;
         cont_s    <= 1'b0;
         dir_up    <= 1'b0;
      end else begin
         done     <= 1'b0;
         step_stb <= 1'b0;
         case (state)
            S_IDLE: begin
               // start wins over a simultaneous stop_req while idle
               if (start) begin
                  start_s   <= f_start;
                  stop_s    <= f_stop;
                  step_s    <= f_step;
                  dwell_s   <= (dwell == '0) ? DWELL_W'(1) : dwell;
                  p_init_s  <= p_init;
                  p_step_s  <= p_step;
                  cont_s    <= cont;
                  dir_up    <= (f_stop >= f_start);
                  f_ctrl    <= f_start;
                  p_ctrl    <= p_init;
                  busy      <= 1'b1;
                  step_stb  <= 1'b1;
                  dwell_cnt <= '0;
                  state     <= S_DWELL;
               end
            end
            S_DWELL: begin
               if (stop_req) begin
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  dwell_cnt <= '0;
                  state     <= S_IDLE;
               end else if (last_dwell) begin
                  dwell_cnt <= '0;
                  if (f_ctrl != stop_s) begin
                     f_ctrl   <= next_f;
                     p_ctrl   <= p_ctrl + p_step_s;
                     step_stb <= 1'b1;
                  end else if (cont_s) begin
                     f_ctrl   <= start_s;
                     p_ctrl   <= p_init_s;
                     step_stb <= 1'b1;
                  end else begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_IDLE;
                  end
               end else begin
                  dwell_cnt <= dwell_cnt + DWELL_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Testbench for dds_sweep_ctrl: directed scenarios plus randomized sweeps,
// checked against a list-of-points reference model built from the sweep rules.
module tb_dds_sweep_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, stop_req, cont;
   logic [19:0] f_start, f_stop, f_step;
   logic [15:0] dwell;
   logic [11:0] p_init, p_step;
   logic [19:0] f_ctrl;
   logic [11:0] p_ctrl;
   logic        busy, done, step_stb;

   int tests  = 0;
   int errors = 0;

   dds_sweep_ctrl #(.F_W(20), .P_W(12), .DWELL_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .stop_req(stop_req), .cont(cont),
      .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
      .p_init(p_init), .p_step(p_step), .f_ctrl(f_ctrl), .p_ctrl(p_ctrl),
      .busy(busy), .done(done), .step_stb(step_stb)
   );

   always #5 clk = ~clk;

   // Observed output bundle: {f_ctrl, p_ctrl, busy, done, step_stb}
   function automatic logic [34:0] obs();
      return {f_ctrl, p_ctrl, busy, done, step_stb};
   endfunction

   task automatic scramble_inputs();
      f_start = 20'($urandom);
      f_stop  = 20'($urandom);
      f_step  = 20'($urandom);
      dwell   = 16'($urandom);
      p_init  = 12'($urandom);
      p_step  = 12'($urandom);
      cont    = 1'($urandom);
   endtask

   // Runs one sweep from an idle DUT (called #1 after a posedge).
   // abort_at: cycle index after the start edge at which stop_req is raised (-1: never).
   // noise: toggle start and scramble settings while busy (must be ignored).
   // with_stop: raise stop_req together with start (start must win).
   task automatic run_sweep(input string name, input int fs, input int fe, input int st,
                            input int dw, input int pi, input int ps, input bit c,
                            input int abort_at, input bit noise, input bit with_stop);
      int qf[$];
      int qp[$];
      int f, p, rem, d, idx, k, cyc;
      logic [34:0] exp;
      // Reference: the ordered list of distinct (f, p) points of one pass
      f = fs; p = pi;
      qf.push_back(f); qp.push_back(p);
      while (f != fe) begin
         rem = (fe >= fs) ? fe - f : f - fe;
         if (st == 0 || st >= rem) f = fe;
         else f = (fe >= fs) ? f + st : f - st;
         p = (p + ps) % 4096;
         qf.push_back(f); qp.push_back(p);
      end
      d = (dw == 0) ? 1 : dw;

      f_start = 20'(fs); f_stop = 20'(fe); f_step = 20'(st); dwell = 16'(dw);
      p_init = 12'(pi); p_step = 12'(ps); cont = c;
      start = 1'b1; stop_req = with_stop;
      @(posedge clk); #1;
      start = 1'b0; stop_req = 1'b0;
      scramble_inputs();

      idx = 0; k = 0;
      for (cyc = 0; cyc < 20000; cyc++) begin
         exp = {20'(qf[idx]), 12'(qp[idx]), 1'b1, 1'b0, (k == 0)};
         tests++;
         if (obs() !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got f=%0d p=%0d busy=%b done=%b stb=%b, want f=%0d p=%0d busy=1 done=0 stb=%b",
                     name, cyc, f_ctrl, p_ctrl, busy, done, step_stb, qf[idx], qp[idx], (k == 0));
         end
         if (cyc == abort_at) begin
            stop_req = 1'b1;
            @(posedge clk); #1;
            stop_req = 1'b0;
            break;
         end
         if (noise) begin
            start = 1'($urandom);
            scramble_inputs();
         end
         @(posedge clk); #1;
         start = 1'b0;
         k++;
         if (k == d) begin
            k = 0;
            idx++;
            if (idx == qf.size()) begin
               if (c) idx = 0;
               else begin
                  idx--;
                  break;
               end
            end
         end
      end

      // End of sweep (normal or abort): busy drops with a one-cycle done pulse
      exp = {20'(qf[idx]), 12'(qp[idx]), 1'b0, 1'b1, 1'b0};
      tests++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL %s end: got f=%0d p=%0d busy=%b done=%b stb=%b, want f=%0d p=%0d busy=0 done=1 stb=0",
                  name, f_ctrl, p_ctrl, busy, done, step_stb, qf[idx], qp[idx]);
      end
      @(posedge clk); #1;
      exp[1] = 1'b0;
      tests++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL %s idle: got f=%0d p=%0d busy=%b done=%b stb=%b, want f=%0d p=%0d busy=0 done=0 stb=0",
                  name, f_ctrl, p_ctrl, busy, done, step_stb, qf[idx], qp[idx]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; stop_req = 1'b0;
      scramble_inputs();
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (obs() !== 35'd0) begin
         errors++;
         $display("FAIL reset: got %h, want 0", obs());
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_up_sweep();
      run_sweep("up_sweep", 1000, 1300, 100, 3, 0, 5, 1'b0, -1, 1'b0, 1'b0);
   endtask

   task automatic test_down_clamp();
      run_sweep("down_clamp", 1250, 1000, 100, 1, 7, 9, 1'b0, -1, 1'b0, 1'b0);
   endtask

   task automatic test_cont_wrap();
      run_sweep("cont_wrap", 10, 20, 10, 2, 4094, 3, 1'b1, 21, 1'b0, 1'b0);
   endtask

   task automatic test_abort();
      logic [34:0] held;
      run_sweep("abort", 1000, 1300, 100, 3, 0, 5, 1'b0, 3, 1'b0, 1'b0);
      // stop_req while idle changes nothing
      held = obs();
      stop_req = 1'b1;
      @(posedge clk); #1;
      stop_req = 1'b0;
      tests++;
      if (obs() !== held) begin
         errors++;
         $display("FAIL idle_stop: got %h, want %h", obs(), held);
      end
      run_sweep("restart", 1000, 1300, 100, 3, 0, 5, 1'b0, -1, 1'b0, 1'b0);
   endtask

   task automatic test_edges();
      run_sweep("dwell0_step0", 1000, 5000, 0, 0, 100, 50, 1'b0, -1, 1'b0, 1'b0);
      run_sweep("single_point", 777, 777, 10, 5, 3, 8, 1'b0, -1, 1'b0, 1'b0);
      run_sweep("huge_step", 20, 1048575, 1048575, 2, 0, 1, 1'b0, -1, 1'b0, 1'b0);
      run_sweep("start_stop_together", 500, 300, 60, 2, 11, 4095, 1'b0, -1, 1'b0, 1'b1);
   endtask

   task automatic test_back_to_back();
      run_sweep("busy_start_ignored", 2000, 2600, 150, 2, 100, 30, 1'b0, -1, 1'b1, 1'b0);
      run_sweep("cont_noise", 300, 100, 70, 3, 4000, 200, 1'b1, 40, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      int fs, fe, delta, st, dw;
      for (int i = 0; i < 25; i++) begin
         fs    = $urandom_range(4000, 1040000);
         delta = $urandom_range(0, 3000);
         fe    = $urandom_range(0, 1) ? fs + delta : fs - delta;
         st    = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(delta / 16 + 1, delta + 50);
         dw    = $urandom_range(0, 4);
         run_sweep("random", fs, fe, st, dw, $urandom_range(0, 4095), $urandom_range(0, 4095),
                   1'b0, -1, 1'($urandom), 1'b0);
      end
   endtask

   task automatic test_async_reset();
      fork
         run_sweep("pre_reset", 1000, 1300, 100, 3, 0, 5, 1'b0, -1, 1'b0, 1'b0);
      join_none
      repeat (4) @(posedge clk);
      #3;
      disable fork;
      rst = 1'b1;
      start = 1'b0; stop_req = 1'b0;
      #1;
      tests++;
      if (obs() !== 35'd0) begin
         errors++;
         $display("FAIL async_reset: got %h, want 0", obs());
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         tests++;
         if (obs() !== 35'd0) begin
            errors++;
            $display("FAIL post_reset cycle %0d: got %h, want 0", i, obs());
         end
      end
   endtask

   initial begin
      test_reset();
      test_up_sweep();
      test_down_clamp();
      test_cont_wrap();
      test_abort();
      test_edges();
      test_back_to_back();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
